rom_dl_router: RTL and testbench
================================

# rom_dl_router

Multi-port ROM download router sitting between `data_io` and the `sdram` controller's write ports in an arcade top level. It filters ioctl byte writes by index, selects a target SDRAM port by address region, converts the byte stream into 16-bit word writes with byte strobes (linear or split-plane packing), and buffers them in a small FIFO. Each port is driven with a toggle req/ack handshake. It generalises the fixed two-port, unbuffered download controller to N ports with per-port packing, back-pressure, overflow detection and a drain-aware `rom_loaded` flag.

## Interface
- `NPORTS`, 2: number of SDRAM write ports (1–4).
- `FIFO_DEPTH`, 4: buffered writes; power of two, ≥2.
- `ROM_INDEX`, 8'd0: `ioctl_index` value accepted.
- `REGION_BASE`, {25'h10000, 25'h0}: packed NPORTS×25 base addresses. Entry 0 must be 0; bases are ascending.
- `SPLIT_MODE`, 2'b10: per-port bit. 0 = linear packing, 1 = split-plane packing.
- `SPLIT_BIT`, 15: local address bit used to select the byte lane in split mode.

- `clk_sys` in 1: system clock.
- `reset_n` in 1: reset; asynchronous, active-low.
- `ioctl_downl` in 1: download active.
- `ioctl_index` in 8: download index.
- `ioctl_wr` in 1: byte strobe; may stay high for several cycles.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `port_req` out NPORTS: per-port toggle request.
- `port_ack` in NPORTS: per-port toggle acknowledge.
- `port_a` out NPORTS×23: word address.
- `port_ds` out NPORTS×2: byte strobes, {upper, lower}.
- `port_d` out NPORTS×16: data; the byte is duplicated on both lanes.
- `port_we` out NPORTS: write enable.
- `busy` out 1: FIFO non-empty or any port pending.
- `rom_loaded` out 1: ROM image fully written.
- `overflow` out 1: sticky; a write was dropped.

## Operation
- **Accept:** a byte is accepted when `ioctl_wr` is high, was low on the previous cycle, `ioctl_downl`=1 and `ioctl_index`==`ROM_INDEX`.
- **Port select:** the highest i with `ioctl_addr` ≥ `REGION_BASE[i]`. Local address `la` = `ioctl_addr` − `REGION_BASE[i]`.
- **Linear packing:** `a` = `la[23:1]`, `ds` = {`la[0]`, ~`la[0]`}.
- **Split-plane packing:** `a` = {`la[23:SPLIT_BIT+1]`, `la[SPLIT_BIT-1:0]`}, truncated to 23 bits; `ds` = {~`la[SPLIT_BIT]`, `la[SPLIT_BIT]`}.
- **FIFO entry:** {port, a, ds, byte}, pushed in order.
- **Push when full:**
  - The byte is dropped and `overflow` is set, unless a pop occurs in the same cycle; then the push is accepted.
  - `overflow` clears on the accepted-download start edge (rising `ioctl_downl` with matching index).
- **Dispatch:** strictly in order; the head blocks until its port is idle. Port i is idle when `port_req[i]`==`port_ack[i]`. On dispatch: pop the head, load `port_a/ds/d[i]` and toggle `port_req[i]`. Outputs hold until the next dispatch to that port.
- **`port_we[i]`:** high while `ioctl_downl` is high or any entry or request is outstanding; low otherwise.
- **`rom_loaded`:**
  - Clears on the accepted-download start edge.
  - Sets on the first cycle where the download has ended (falling `ioctl_downl` seen), the FIFO is empty and all ports are idle.
  - Stays 0 until the last buffered write is acknowledged.
  - Stays set across non-matching-index downloads.
- **Reset (async, any time, including mid-download):**
  - FIFO empty.
  - `port_req`, `port_a`, `port_ds`, `port_d`, `port_we` = 0.
  - `busy` = 0, `overflow` = 0, `rom_loaded` = 0.
  - Edge-detect registers = 0.

## Timing
- Byte accepted at clock edge t (FIFO entry visible at t+1). Earliest dispatch is edge t+1, so `port_req` toggles 1 cycle after acceptance.
- An empty-FIFO bypass is not required.
- Sustained rate: one dispatch per cycle across ports; one dispatch per ack round-trip per port.
- `busy` is registered and reflects state after each edge.
- `rom_loaded` rises 1 cycle after the final `port_ack` match, or 1 cycle after `ioctl_downl` falls if already drained.

## Structure
- **Package `rom_dl_pkg`:** `dl_entry_t` struct {port idx [1:0], a [22:0], ds [1:0], d [7:0]}, a `pack_mode_e` {PACK_LINEAR, PACK_SPLIT} enum, and `PORT_AW`=23 / `IOCTL_AW`=25 constants.
- **Sub-module `rom_dl_fifo`:** synchronous FIFO of `dl_entry_t`, `FIFO_DEPTH` entries, with push/pop/full/empty. It must allow a simultaneous push and pop when full.
- Region decode and the dispatcher live in `rom_dl_router`.

## Test plan
- **Linear port 0:** write addr 0x00003 data 0xA5 (defaults) -> port 0: `a`=1, `ds`=2'b10, `d`=0xA5A5, `port_req[0]` toggles.
- **Split port 1:** write addr 0x18004 data 0x3C -> port 1: `la`=0x8004, `a`=0x0004, `ds`=2'b01, `d`=0x3C3C.
- **Back-pressure:** hold `port_ack[0]` static and issue 5 writes to port 0 -> 1 dispatched, 4 buffered, 0 dropped. A 6th write sets `overflow`, `busy`=1. Release acks -> dispatches in address order; `overflow` stays 1 until the next download start.
- **Drain-aware loaded:** drop `ioctl_downl` with 2 entries pending -> `rom_loaded`=0 until the second ack matches, then 1 on the next cycle.
- **Filter / held strobe:** `ioctl_index`=1 writes -> no push, `rom_loaded` unchanged. `ioctl_wr` held high 4 cycles -> exactly one entry pushed.
- **Async reset mid-download:** assert `reset_n`=0 with 3 entries queued -> all outputs 0 immediately, without waiting for a clock edge. After release, a write at 0x0 produces a single toggle on `port_req[0]`.

Source files
------------

// File: rtl/rom_dl_pkg.sv
// Shared types and widths for the ROM download router: the buffered write
// entry and the per-port byte packing mode.
package rom_dl_pkg;

    localparam int PORT_AW  = 23;
    localparam int IOCTL_AW = 25;

    typedef enum logic {
        PACK_LINEAR = 1'b0,
        PACK_SPLIT  = 1'b1
    } pack_mode_e;

    typedef struct packed {
        logic [1:0]         port;
        logic [PORT_AW-1:0] a;
        logic [1:0]         ds;
        logic [7:0]         d;
    } dl_entry_t;

endpackage

// File: rtl/rom_dl_fifo.sv
// Small in-order FIFO of pending SDRAM word writes. A push into a full FIFO
// is taken only when a pop happens in the same cycle.
module rom_dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  dl_entry_t              push_data_i,
    input  logic                   pop_i,
    output dl_entry_t              head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dl_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    always_comb begin
        full_o   = (count_q == CW'(DEPTH));
        empty_o  = (count_q == '0);
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        head_o   = mem_q[rd_ptr_q];
        count_o  = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rom_dl_router.sv
// Routes ioctl ROM download bytes to N SDRAM write ports by address region,
// packing bytes into strobed 16-bit writes buffered through a small FIFO.
module rom_dl_router
    import rom_dl_pkg::*;
#(
    parameter int                         NPORTS      = 2,
    parameter int                         FIFO_DEPTH  = 4,
    parameter logic [7:0]                 ROM_INDEX   = 8'd0,
    parameter logic [NPORTS*IOCTL_AW-1:0] REGION_BASE = {25'h10000, 25'h0},
    parameter logic [NPORTS-1:0]          SPLIT_MODE  = 2'b10,
    parameter int                         SPLIT_BIT   = 15
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        ioctl_downl,
    input  logic [7:0]                  ioctl_index,
    input  logic                        ioctl_wr,
    input  logic [IOCTL_AW-1:0]         ioctl_addr,
    input  logic [7:0]                  ioctl_dout,
    output logic [NPORTS-1:0]           port_req,
    input  logic [NPORTS-1:0]           port_ack,
    output logic [NPORTS*PORT_AW-1:0]   port_a,
    output logic [NPORTS*2-1:0]         port_ds,
    output logic [NPORTS*16-1:0]        port_d,
    output logic [NPORTS-1:0]           port_we,
    output logic                        busy,
    output logic                        rom_loaded,
    output logic                        overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IOCTL_AW-1:0] LO_MASK = (IOCTL_AW'(1) << SPLIT_BIT) - IOCTL_AW'(1);

    logic                      wr_prev_q, downl_prev_q;
    logic                      accept, dl_start, dl_end;
    logic [1:0]                sel;
    logic [IOCTL_AW-1:0]       base, la;
    pack_mode_e                mode;
    dl_entry_t                 new_entry, head;
    logic                      fifo_full, fifo_empty;
    logic [CW-1:0]             fifo_count, count_d;
    logic [NPORTS-1:0]         idle;
    logic                      head_idle, dispatch, drop;
    logic [NPORTS-1:0]         port_req_q, port_req_d;
    logic [NPORTS*PORT_AW-1:0] port_a_q;
    logic [NPORTS*2-1:0]       port_ds_q;
    logic [NPORTS*16-1:0]      port_d_q;
    logic [NPORTS-1:0]         port_we_q;
    logic                      busy_q, busy_d;
    logic                      overflow_q, overflow_d;
    logic                      loaded_q, loaded_d;
    logic                      armed_q, armed_d;
    logic                      ended_q, ended_d;

    always_comb begin
        accept   = ioctl_wr && !wr_prev_q && ioctl_downl && (ioctl_index == ROM_INDEX);
        dl_start = ioctl_downl && !downl_prev_q && (ioctl_index == ROM_INDEX);
        dl_end   = downl_prev_q && !ioctl_downl;
    end

    // Region decode: bases ascend, so the last base not above the address wins.
    always_comb begin
        sel  = '0;
        base = '0;
        mode = PACK_LINEAR;
        for (int i = 0; i < NPORTS; i++) begin
            if (ioctl_addr >= REGION_BASE[i*IOCTL_AW +: IOCTL_AW]) begin
                sel  = 2'(i);
                base = REGION_BASE[i*IOCTL_AW +: IOCTL_AW];
                mode = pack_mode_e'(SPLIT_MODE[i]);
            end
        end
        la = ioctl_addr - base;

        new_entry      = '0;
        new_entry.port = sel;
        new_entry.d    = ioctl_dout;
        if (mode == PACK_SPLIT) begin
            // Drop the plane-select bit from the word address; it picks the lane.
            new_entry.a  = PORT_AW'((la >> (SPLIT_BIT + 1)) << SPLIT_BIT) | PORT_AW'(la & LO_MASK);
            new_entry.ds = {~la[SPLIT_BIT], la[SPLIT_BIT]};
        end else begin
            new_entry.a  = la[PORT_AW:1];
            new_entry.ds = {la[0], ~la[0]};
        end
    end

    rom_dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_sys),
        .rst_ni      (reset_n),
        .push_i      (accept),
        .push_data_i (new_entry),
        .pop_i       (dispatch),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Toggle handshake: a port owes an ack while port_req[i] != port_ack[i];
    // a new write is issued only to an idle port by flipping port_req[i].
    always_comb begin
        idle      = ~(port_req_q ^ port_ack);
        head_idle = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (head.port == 2'(i)) begin
                head_idle = idle[i];
            end
        end
        dispatch   = !fifo_empty && head_idle;
        drop       = accept && fifo_full && !dispatch;
        port_req_d = port_req_q;
        for (int i = 0; i < NPORTS; i++) begin
            if (dispatch && head.port == 2'(i)) begin
                port_req_d[i] = ~port_req_q[i];
            end
        end
        count_d = fifo_count + CW'(accept && !drop) - CW'(dispatch);
        busy_d  = (count_d != '0) || (|(port_req_d ^ port_ack));
    end

    always_comb begin
        overflow_d = overflow_q;
        loaded_d   = loaded_q;
        armed_d    = armed_q;
        ended_d    = ended_q;
        if (dl_start) begin
            overflow_d = 1'b0;
            loaded_d   = 1'b0;
            armed_d    = 1'b1;
            ended_d    = 1'b0;
        end else if (armed_q) begin
            if ((ended_q || dl_end) && fifo_empty && (&idle)) begin
                loaded_d = 1'b1;
                armed_d  = 1'b0;
                ended_d  = 1'b0;
            end else if (dl_end) begin
                ended_d = 1'b1;
            end
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev_q    <= 1'b0;
            downl_prev_q <= 1'b0;
            port_req_q   <= '0;
            port_a_q     <= '0;
            port_ds_q    <= '0;
            port_d_q     <= '0;
            port_we_q    <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            loaded_q     <= 1'b0;
            armed_q      <= 1'b0;
            ended_q      <= 1'b0;
        end else begin
            wr_prev_q    <= ioctl_wr;
            downl_prev_q <= ioctl_downl;
            port_req_q   <= port_req_d;
            for (int i = 0; i < NPORTS; i++) begin
                if (dispatch && head.port == 2'(i)) begin
                    port_a_q[i*PORT_AW +: PORT_AW] <= head.a;
                    port_ds_q[i*2 +: 2]            <= head.ds;
                    port_d_q[i*16 +: 16]           <= {head.d, head.d};
                end
            end
            port_we_q    <= {NPORTS{ioctl_downl || busy_d}};
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            loaded_q     <= loaded_d;
            armed_q      <= armed_d;
            ended_q      <= ended_d;
        end
    end

    assign port_req   = port_req_q;
    assign port_a     = port_a_q;
    assign port_ds    = port_ds_q;
    assign port_d     = port_d_q;
    assign port_we    = port_we_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign rom_loaded = loaded_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router with default parameters (two ports,
// port 1 split-plane at 0x10000, four-entry FIFO).
module tb_rom_dl_router;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_downl = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [1:0]  port_req;
    logic [1:0]  port_ack = 2'b00;
    logic [45:0] port_a;
    logic [3:0]  port_ds;
    logic [31:0] port_d;
    logic [1:0]  port_we;
    logic        busy;
    logic        rom_loaded;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [22:0] exp_q[$];

    rom_dl_router dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .port_req    (port_req),
        .port_ack    (port_ack),
        .port_a      (port_a),
        .port_ds     (port_ds),
        .port_d      (port_d),
        .port_we     (port_we),
        .busy        (busy),
        .rom_loaded  (rom_loaded),
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic write_byte(input logic [24:0] addr, input logic [7:0] data, input int hold);
        @(negedge clk_sys);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        repeat (hold) @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic ack_port(input int p);
        @(negedge clk_sys);
        port_ack[p] = ~port_ack[p];
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (port_req !== 2'b00) $display("FAIL rst_req: got %b want 00", port_req); else n_pass++;
        n_checks++; if (port_a !== 46'h0) $display("FAIL rst_a: got %h want 0", port_a); else n_pass++;
        n_checks++; if (port_we !== 2'b00) $display("FAIL rst_we: got %b want 00", port_we); else n_pass++;
        n_checks++; if ({busy, overflow, rom_loaded} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, overflow, rom_loaded}); else n_pass++;
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_linear;
        @(negedge clk_sys);
        ioctl_index = 8'd0;
        ioctl_downl = 1'b1;
        tick(1);
        n_checks++; if (port_we !== 2'b11) $display("FAIL lin_we: got %b want 11", port_we); else n_pass++;
        write_byte(25'h00003, 8'hA5, 1);
        tick(1);
        n_checks++; if (port_req !== 2'b01) $display("FAIL lin_req: got %b want 01", port_req); else n_pass++;
        n_checks++; if (port_a[22:0] !== 23'h1) $display("FAIL lin_a: got %h want 1", port_a[22:0]); else n_pass++;
        n_checks++; if (port_ds[1:0] !== 2'b10) $display("FAIL lin_ds: got %b want 10", port_ds[1:0]); else n_pass++;
        n_checks++; if (port_d[15:0] !== 16'hA5A5) $display("FAIL lin_d: got %h want a5a5", port_d[15:0]); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL lin_busy: got %b want 1", busy); else n_pass++;
        ack_port(0);
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL lin_idle: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_split;
        write_byte(25'h18004, 8'h3C, 1);
        tick(1);
        n_checks++; if (port_req !== 2'b11) $display("FAIL spl_req: got %b want 11", port_req); else n_pass++;
        n_checks++; if (port_a[45:23] !== 23'h4) $display("FAIL spl_a: got %h want 4", port_a[45:23]); else n_pass++;
        n_checks++; if (port_ds[3:2] !== 2'b01) $display("FAIL spl_ds: got %b want 01", port_ds[3:2]); else n_pass++;
        n_checks++; if (port_d[31:16] !== 16'h3C3C) $display("FAIL spl_d: got %h want 3c3c", port_d[31:16]); else n_pass++;
        ack_port(1);
        tick(1);
    endtask

    task automatic test_back_pressure;
        logic [22:0] exp_a;
        for (int k = 0; k < 5; k++) begin
            write_byte(25'h20 + 25'(2 * k), 8'h40 + 8'(k), 1);
            if (k > 0) exp_q.push_back(23'h10 + 23'(k));
        end
        tick(1);
        n_checks++; if (port_a[22:0] !== 23'h10) $display("FAIL bp_first_a: got %h want 10", port_a[22:0]); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL bp_no_ovf: got %b want 0", overflow); else n_pass++;
        write_byte(25'h2A, 8'h99, 1);
        tick(1);
        n_checks++; if (overflow !== 1'b1) $display("FAIL bp_ovf: got %b want 1", overflow); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else n_pass++;
        while (exp_q.size() > 0) begin
            exp_a = exp_q.pop_front();
            ack_port(0);
            tick(1);
            n_checks++; if (port_a[22:0] !== exp_a) $display("FAIL bp_order: got %h want %h", port_a[22:0], exp_a); else n_pass++;
            n_checks++; if (port_req[0] !== ~port_ack[0]) $display("FAIL bp_req: got %b want %b", port_req[0], ~port_ack[0]); else n_pass++;
        end
        ack_port(0);
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_drained: got %b want 0", busy); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL bp_ovf_sticky: got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_drain_loaded;
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        tick(1);
        n_checks++; if (rom_loaded !== 1'b1) $display("FAIL dl_loaded_idle: got %b want 1", rom_loaded); else n_pass++;
        n_checks++; if (port_we !== 2'b00) $display("FAIL dl_we_off: got %b want 00", port_we); else n_pass++;
        @(negedge clk_sys);
        ioctl_downl = 1'b1;
        tick(1);
        n_checks++; if (rom_loaded !== 1'b0) $display("FAIL dl_loaded_clr: got %b want 0", rom_loaded); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL dl_ovf_clr: got %b want 0", overflow); else n_pass++;
        for (int k = 0; k < 3; k++) write_byte(25'h100 + 25'(2 * k), 8'h60 + 8'(k), 1);
        tick(1);
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        tick(2);
        n_checks++; if (rom_loaded !== 1'b0) $display("FAIL dl_pending: got %b want 0", rom_loaded); else n_pass++;
        n_checks++; if (port_we !== 2'b11) $display("FAIL dl_we_pending: got %b want 11", port_we); else n_pass++;
        ack_port(0);
        tick(1);
        n_checks++; if (port_a[22:0] !== 23'h81) $display("FAIL dl_a2: got %h want 81", port_a[22:0]); else n_pass++;
        ack_port(0);
        tick(1);
        n_checks++; if (rom_loaded !== 1'b0) $display("FAIL dl_last_out: got %b want 0", rom_loaded); else n_pass++;
        ack_port(0);
        tick(1);
        n_checks++; if (rom_loaded !== 1'b1) $display("FAIL dl_loaded_set: got %b want 1", rom_loaded); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL dl_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_filter;
        @(negedge clk_sys);
        ioctl_index = 8'd1;
        ioctl_downl = 1'b1;
        write_byte(25'h0, 8'h11, 1);
        write_byte(25'h1, 8'h22, 1);
        tick(2);
        n_checks++; if (port_req !== port_ack) $display("FAIL flt_req: got %b want %b", port_req, port_ack); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL flt_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rom_loaded !== 1'b1) $display("FAIL flt_loaded: got %b want 1", rom_loaded); else n_pass++;
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        tick(2);
        n_checks++; if (rom_loaded !== 1'b1) $display("FAIL flt_loaded_end: got %b want 1", rom_loaded); else n_pass++;
        ioctl_index = 8'd0;
        ioctl_downl = 1'b1;
        write_byte(25'h40, 8'h77, 4);
        tick(1);
        n_checks++; if (port_req !== (port_ack ^ 2'b01)) $display("FAIL hold_req: got %b want %b", port_req, port_ack ^ 2'b01); else n_pass++;
        n_checks++; if (port_d[15:0] !== 16'h7777) $display("FAIL hold_d: got %h want 7777", port_d[15:0]); else n_pass++;
        ack_port(0);
        tick(3);
        n_checks++; if (port_req !== port_ack) $display("FAIL hold_single: got %b want %b", port_req, port_ack); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 4; k++) write_byte(25'h200 + 25'(2 * k), 8'hC0 + 8'(k), 1);
        tick(1);
        @(negedge clk_sys);
        #2;
        reset_n  = 1'b0;
        port_ack = 2'b00;
        #1;
        n_checks++; if (port_req !== 2'b00) $display("FAIL ar_req: got %b want 00", port_req); else n_pass++;
        n_checks++; if (port_a !== 46'h0) $display("FAIL ar_a: got %h want 0", port_a); else n_pass++;
        n_checks++; if ({port_ds, port_d} !== 36'h0) $display("FAIL ar_ds_d: got %h want 0", {port_ds, port_d}); else n_pass++;
        n_checks++; if (port_we !== 2'b00) $display("FAIL ar_we: got %b want 00", port_we); else n_pass++;
        n_checks++; if ({busy, overflow, rom_loaded} !== 3'b000) $display("FAIL ar_flags: got %b want 000", {busy, overflow, rom_loaded}); else n_pass++;
        @(negedge clk_sys);
        reset_n = 1'b1;
        write_byte(25'h0, 8'h5A, 1);
        tick(1);
        n_checks++; if (port_req !== 2'b01) $display("FAIL ar_post_req: got %b want 01", port_req); else n_pass++;
        n_checks++; if (port_a !== 46'h0) $display("FAIL ar_post_a: got %h want 0", port_a); else n_pass++;
        n_checks++; if (port_d !== 32'h00005A5A) $display("FAIL ar_post_d: got %h want 00005a5a", port_d); else n_pass++;
        ack_port(0);
        tick(3);
        n_checks++; if (port_req !== 2'b01) $display("FAIL ar_single: got %b want 01", port_req); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_linear();
        test_split();
        test_back_pressure();
        test_drain_loaded();
        test_filter();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
